// File: rtl/in_fea_stream_if.sv
// Handshake and preload bundle for the input-feature streamer.
// master is the streamer side, slave is the producer/consumer side.
interface in_fea_stream_if #(
  parameter int DATA_W  = 16,
  parameter int VEC_LEN = 25,
  parameter int CHN     = 3,
  parameter int COLS    = 25,
  parameter int ROWS    = 150,
  parameter int PASSES  = 4,
  parameter int ADDR_W  = 9
);
  localparam int VW = VEC_LEN * DATA_W;
  localparam int CW = (CHN    > 1) ? $clog2(CHN)    : 1;
  localparam int LW = (COLS   > 1) ? $clog2(COLS)   : 1;
  localparam int RW = (ROWS   > 1) ? $clog2(ROWS)   : 1;
  localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;

  logic              start;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [VW-1:0]     wr_data;
  logic              out_ready;
  logic              out_valid;
  logic [VW-1:0]     out_data;
  logic [CW-1:0]     out_chn;
  logic [LW-1:0]     out_col;
  logic [RW-1:0]     out_row;
  logic [PW-1:0]     out_pass;
  logic              out_last_pass;
  logic              busy;
  logic              done;

  modport master (
    input  start, wr_en, wr_addr, wr_data, out_ready,
    output out_valid, out_data, out_chn, out_col, out_row, out_pass,
           out_last_pass, busy, done
  );

  modport slave (
    output start, wr_en, wr_addr, wr_data, out_ready,
    input  out_valid, out_data, out_chn, out_col, out_row, out_pass,
           out_last_pass, busy, done
  );
endinterface

// File: rtl/in_fea_stream.sv
// Input-feature streamer: replays a preloaded feature map as a lossless
// valid/ready vector stream (chn -> col -> row -> pass), PASSES times per start.
module in_fea_stream #(
  parameter int DATA_W  = 16,
  parameter int VEC_LEN = 25,
  parameter int CHN     = 3,
  parameter int COLS    = 25,
  parameter int ROWS    = 150,
  parameter int PASSES  = 4,
  parameter int ADDR_W  = 9
) (
  input logic clk,
  input logic rst,
  in_fea_stream_if.master bus
);
  localparam int VW = VEC_LEN * DATA_W;
  localparam int CW = (CHN    > 1) ? $clog2(CHN)    : 1;
  localparam int LW = (COLS   > 1) ? $clog2(COLS)   : 1;
  localparam int RW = (ROWS   > 1) ? $clog2(ROWS)   : 1;
  localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam int TW = PW + RW + LW + CW + 1;

  localparam logic [CW-1:0]     CHN_MAX  = CW'(CHN - 1);
  localparam logic [LW-1:0]     COL_MAX  = LW'(COLS - 1);
  localparam logic [RW-1:0]     ROW_MAX  = RW'(ROWS - 1);
  localparam logic [PW-1:0]     PASS_MAX = PW'(PASSES - 1);
  localparam logic [ADDR_W:0]   DEPTH    = (ADDR_W + 1)'(ROWS * CHN);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t            state;
  logic [CW-1:0]     chn_c;
  logic [LW-1:0]     col_c;
  logic [RW-1:0]     row_c;
  logic [PW-1:0]     pass_c;
  logic [ADDR_W-1:0] row_base;
  logic              busy_q;
  logic              done_q;

  logic [VW-1:0]     mem [0:2**ADDR_W-1];
  logic [VW-1:0]     fifo_data [0:1];
  logic [TW-1:0]     fifo_tag  [0:1];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;

  logic              issue;
  logic              pop;
  logic              beat_last;
  logic              last_issue;
  logic [ADDR_W-1:0] rd_addr;

  always_comb begin
    issue      = (state == ISSUE) && (count < 2'd2);
    pop        = (count != 2'd0) && bus.out_ready;
    beat_last  = (chn_c == CHN_MAX) && (col_c == COL_MAX) && (row_c == ROW_MAX);
    last_issue = beat_last && (pass_c == PASS_MAX);
    rd_addr    = row_base + ADDR_W'(chn_c);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      chn_c    <= '0;
      col_c    <= '0;
      row_c    <= '0;
      pass_c   <= '0;
      row_base <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state    <= ISSUE;
            busy_q   <= 1'b1;
            chn_c    <= '0;
            col_c    <= '0;
            row_c    <= '0;
            pass_c   <= '0;
            row_base <= '0;
          end
        end
        ISSUE: begin
          if (issue) begin
            // Each wrap carries into the next-outer counter in the same cycle;
            // row_base only moves with the row so every column re-reads the row.
            if (chn_c == CHN_MAX) begin
              chn_c <= '0;
              if (col_c == COL_MAX) begin
                col_c <= '0;
                if (row_c == ROW_MAX) begin
                  row_c    <= '0;
                  row_base <= '0;
                  pass_c   <= (pass_c == PASS_MAX) ? '0 : pass_c + PW'(1);
                end else begin
                  row_c    <= row_c + RW'(1);
                  row_base <= row_base + ADDR_W'(CHN);
                end
              end else begin
                col_c <= col_c + LW'(1);
              end
            end else begin
              chn_c <= chn_c + CW'(1);
            end
            if (last_issue) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (count == 2'd0) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        DONE: state <= IDLE;
      endcase
    end
  end

  // The RAM's output register is the FIFO tail slot, so a read issued in one
  // cycle is presentable in the next and the issue rule alone bounds occupancy.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
        fifo_tag[i]  <= '0;
      end
    end else begin
      if (issue) begin
        fifo_data[wr_ptr] <= mem[rd_addr];
        fifo_tag[wr_ptr]  <= {pass_c, row_c, col_c, chn_c, beat_last};
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({issue, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if ((state == IDLE) && bus.wr_en && ({1'b0, bus.wr_addr} < DEPTH))
      mem[bus.wr_addr] <= bus.wr_data;
  end

  assign bus.out_valid = (count != 2'd0);
  assign bus.out_data  = fifo_data[rd_ptr];
  assign {bus.out_pass, bus.out_row, bus.out_col, bus.out_chn, bus.out_last_pass} = fifo_tag[rd_ptr];
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_in_fea_stream.sv
// Scoreboard bench: a small-parameter streamer exercised with varied
// backpressure, reset and write corner cases, plus one full default-size run.
module tb_in_fea_stream;
  logic clk;
  logic s_rst;
  logic b_rst;

  int unsigned checks = 0;
  int unsigned errors = 0;

  in_fea_stream_if #(.DATA_W(16), .VEC_LEN(2), .CHN(2), .COLS(3), .ROWS(2), .PASSES(2), .ADDR_W(3)) s_if ();
  in_fea_stream_if #(.DATA_W(16), .VEC_LEN(25), .CHN(3), .COLS(25), .ROWS(150), .PASSES(4), .ADDR_W(9)) b_if ();

  in_fea_stream #(.DATA_W(16), .VEC_LEN(2), .CHN(2), .COLS(3), .ROWS(2), .PASSES(2), .ADDR_W(3))
    u_small (.clk(clk), .rst(s_rst), .bus(s_if));
  in_fea_stream #(.DATA_W(16), .VEC_LEN(25), .CHN(3), .COLS(25), .ROWS(150), .PASSES(4), .ADDR_W(9))
    u_big (.clk(clk), .rst(b_rst), .bus(b_if));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // ---------------- small instance: model, ready driver, monitor ----------------
  logic [31:0]  s_ref [0:3];
  logic [37:0]  s_q [$];
  int unsigned  s_rmode = 0;
  int unsigned  s_beats = 0;
  int unsigned  s_done_cnt = 0;
  int unsigned  s_busy_cycles = 0;
  logic         s_prev_stall = 1'b0;
  logic [37:0]  s_prev_vec = '0;

  task automatic s_push();
    for (int p = 0; p < 2; p++)
      for (int r = 0; r < 2; r++)
        for (int c = 0; c < 3; c++)
          for (int ch = 0; ch < 2; ch++)
            s_q.push_back({s_ref[r*2+ch], 1'(p), 1'(r), 2'(c), 1'(ch), (r == 1 && c == 2 && ch == 1)});
  endtask

  initial begin
    s_if.out_ready = 1'b1;
    for (int unsigned k = 0; ; k++) begin
      @(posedge clk);
      #1;
      case (s_rmode)
        1:       s_if.out_ready = ((k % 4) == 0) || ((k % 4) == 3);
        2:       s_if.out_ready = 1'($urandom_range(0, 1));
        default: s_if.out_ready = 1'b1;
      endcase
    end
  end

  always @(negedge clk) begin
    logic [37:0] got;
    got = {s_if.out_data, s_if.out_pass, s_if.out_row, s_if.out_col, s_if.out_chn, s_if.out_last_pass};
    if (s_if.busy) s_busy_cycles++;
    if (s_rst && s_prev_stall)
      chk("s_hold", {s_if.out_valid, got}, {1'b1, s_prev_vec});
    if (s_rst && s_if.out_valid && s_if.out_ready) begin
      if (s_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL s_extra_beat got=%0h required=none", got);
      end else begin
        chk("s_beat", got, s_q.pop_front());
      end
      s_beats++;
    end
    if (s_rst && s_if.done) begin
      s_done_cnt++;
      chk("s_done_drained", s_q.size(), 0);
    end
    s_prev_stall = s_rst && s_if.out_valid && !s_if.out_ready;
    s_prev_vec   = got;
  end

  task automatic s_wr(input logic [2:0] a, input logic [31:0] d);
    s_if.wr_en = 1'b1; s_if.wr_addr = a; s_if.wr_data = d;
    @(posedge clk); #1;
    s_if.wr_en = 1'b0;
  endtask

  task automatic s_run(input bit lat, input bit disturb, input bit cw,
                       input logic [2:0] ca, input logic [31:0] cd);
    int unsigned prev;
    int unsigned n;
    s_push();
    s_busy_cycles = 0;
    prev = s_done_cnt;
    s_if.start = 1'b1;
    if (cw) begin
      s_if.wr_en = 1'b1; s_if.wr_addr = ca; s_if.wr_data = cd;
    end
    @(posedge clk); #1;
    s_if.start = 1'b0;
    s_if.wr_en = 1'b0;
    if (lat) begin
      @(negedge clk);
      chk("s_lat_t1", {s_if.busy, s_if.out_valid}, 2'b10);
      @(negedge clk);
      chk("s_lat_t2", s_if.out_valid, 1'b1);
    end
    if (disturb) begin
      repeat (5) @(posedge clk);
      #1;
      s_if.start = 1'b1; s_if.wr_en = 1'b1; s_if.wr_addr = 3'd0; s_if.wr_data = ~s_ref[0];
      @(posedge clk); #1;
      s_if.start = 1'b0; s_if.wr_en = 1'b0;
    end
    n = 0;
    while (s_done_cnt == prev && n < 2000) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (s_done_cnt == prev) begin
      checks++;
      errors++;
      $display("FAIL s_done_timeout got=no_done required=done");
    end
  endtask

  // ---------------- big instance: model and monitor ----------------
  logic [399:0] b_ref [0:449];
  logic [417:0] b_q [$];
  int unsigned  b_beats = 0;
  int unsigned  b_last = 0;
  int unsigned  b_done_cnt = 0;
  int unsigned  b_busy_cycles = 0;

  always @(negedge clk) begin
    if (b_rst) begin
      if (b_if.busy) b_busy_cycles++;
      if (b_if.out_valid && b_if.out_ready) begin
        if (b_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL b_extra_beat got_row=%0d required=none", b_if.out_row);
        end else begin
          chk("b_beat", {b_if.out_data, b_if.out_pass, b_if.out_row, b_if.out_col,
                         b_if.out_chn, b_if.out_last_pass}, b_q.pop_front());
        end
        b_beats++;
        if (b_if.out_last_pass) b_last++;
      end
      if (b_if.done) begin
        b_done_cnt++;
        chk("b_done_drained", b_q.size(), 0);
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0]  nv;
    logic [399:0] bv;
    int unsigned  base;
    int unsigned  dcnt;
    int unsigned  n;

    s_rst = 1'b0; b_rst = 1'b0;
    s_if.start = 1'b0; s_if.wr_en = 1'b0; s_if.wr_addr = '0; s_if.wr_data = '0;
    b_if.start = 1'b0; b_if.wr_en = 1'b0; b_if.wr_addr = '0; b_if.wr_data = '0;
    b_if.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    s_rst = 1'b1; b_rst = 1'b1;
    @(negedge clk);
    chk("s_reset_state", {s_if.out_valid, s_if.out_data, s_if.out_pass, s_if.out_row, s_if.out_col,
                          s_if.out_chn, s_if.out_last_pass, s_if.busy, s_if.done}, '0);
    chk("b_reset_state", {b_if.out_valid, b_if.out_data, b_if.out_pass, b_if.out_row, b_if.out_col,
                          b_if.out_chn, b_if.out_last_pass, b_if.busy, b_if.done}, '0);
    @(posedge clk); #1;

    // Preload word k = {k,k}, free-flowing output.
    for (int k = 0; k < 4; k++) begin
      s_ref[k] = {16'(k), 16'(k)};
      s_wr(3'(k), s_ref[k]);
    end
    s_run(1'b1, 1'b0, 1'b0, 3'd0, 32'd0);
    chk("s_busy_len", s_busy_cycles, 26);

    // 1,0,0,1 backpressure pattern.
    s_rmode = 1;
    s_run(1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
    s_rmode = 0;

    // Random contents with random backpressure.
    for (int k = 0; k < 4; k++) begin
      s_ref[k] = $urandom;
      s_wr(3'(k), s_ref[k]);
    end
    s_rmode = 2;
    s_run(1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
    s_rmode = 0;

    // Reset after about ten beats aborts the run without a done pulse.
    base = s_beats;
    s_push();
    s_if.start = 1'b1;
    @(posedge clk); #1;
    s_if.start = 1'b0;
    for (int i = 0; i < 100 && (s_beats - base) < 10; i++) @(posedge clk);
    #1;
    chk("s_rst_reached", (s_beats - base) >= 10, 1'b1);
    s_rst = 1'b0;
    @(posedge clk); #1;
    s_rst = 1'b1;
    s_q.delete();
    dcnt = s_done_cnt;
    @(negedge clk);
    chk("s_rst_abort", {s_if.out_valid, s_if.busy, s_if.done}, 3'b000);
    repeat (6) @(posedge clk);
    #1;
    chk("s_rst_no_done", s_done_cnt, dcnt);
    s_run(1'b0, 1'b0, 1'b0, 3'd0, 32'd0);

    // Writes and start while busy are ignored; the old word streams.
    s_run(1'b0, 1'b1, 1'b0, 3'd0, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("s_idle_after_busy_start", s_if.busy, 1'b0);

    // Rewrite in IDLE is visible; out-of-range address is dropped; a write
    // coincident with start lands before the run reads it.
    nv = $urandom;
    s_ref[0] = nv;
    s_wr(3'd0, nv);
    s_wr(3'd4, 32'hDEAD_BEEF);
    nv = $urandom;
    s_ref[1] = nv;
    s_run(1'b0, 1'b0, 1'b1, 3'd1, nv);

    // Full default-size run.
    for (int a = 0; a < 450; a++) begin
      for (int j = 0; j < 25; j++) bv[j*16 +: 16] = 16'($urandom);
      b_ref[a] = bv;
      b_if.wr_en = 1'b1; b_if.wr_addr = 9'(a); b_if.wr_data = bv;
      @(posedge clk); #1;
    end
    b_if.wr_en = 1'b0;
    for (int p = 0; p < 4; p++)
      for (int r = 0; r < 150; r++)
        for (int c = 0; c < 25; c++)
          for (int ch = 0; ch < 3; ch++)
            b_q.push_back({b_ref[r*3+ch], 2'(p), 8'(r), 5'(c), 2'(ch), (r == 149 && c == 24 && ch == 2)});
    b_busy_cycles = 0;
    b_if.start = 1'b1;
    @(posedge clk); #1;
    b_if.start = 1'b0;
    n = 0;
    while (b_done_cnt == 0 && n < 50000) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (b_done_cnt == 0) begin
      checks++;
      errors++;
      $display("FAIL b_done_timeout got=no_done required=done");
    end
    chk("b_beat_count", b_beats, 45000);
    chk("b_last_count", b_last, 4);
    chk("b_busy_len", b_busy_cycles, 45002);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
